// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared symbol, button and state definitions for the lock code sender
package lock_pkg;

  localparam logic [1:0] SYM_A = 2'b00;
  localparam logic [1:0] SYM_B = 2'b01;
  localparam logic [1:0] SYM_C = 2'b10;
  localparam logic [1:0] SYM_D = 2'b11;

  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;
  localparam int BTN_D = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Maps a 2-bit code symbol to the single button line it drives.
  function automatic logic [3:0] sym_to_onehot(input logic [1:0] sym);
    logic [3:0] oh;
    oh = '0;
    case (sym)
      SYM_A:   oh[BTN_A] = 1'b1;
      SYM_B:   oh[BTN_B] = 1'b1;
      SYM_C:   oh[BTN_C] = 1'b1;
      SYM_D:   oh[BTN_D] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/lock_code_sender_if.sv
// rtl/lock_code_sender_if.sv - host-side control and button drive bundle of the lock code sender
interface lock_code_sender_if #(
  parameter int CODE_LEN = 4
);
  logic                  start;
  logic [2*CODE_LEN-1:0] code;
  logic                  abort;
  logic [3:0]            btn;
  logic                  busy;
  logic                  done;
  logic [2:0]            step;

  // Host / bench side: requests sequences and watches the button drive.
  modport master (
    output start, code, abort,
    input  btn, busy, done, step
  );

  // Sender side.
  modport slave (
    input  start, code, abort,
    output btn, busy, done, step
  );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter timing the press and release phases
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload on phase entry, otherwise count down and park at 1 so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q > W'(1)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last cycle of a phase is the one where the count reads 1.
  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/lock_code_sender.sv
// rtl/lock_code_sender.sv - plays a latched code as timed one-hot button presses
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int CODE_LEN    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 16
) (
  input logic              clk,
  input logic              rst,
  lock_code_sender_if.slave bus
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] GAP_LD    = TW'(GAP_CYCLES);
  localparam logic [2:0]    LAST_STEP = 3'(CODE_LEN - 1);

  state_t                state_q, state_d;
  logic [2*CODE_LEN-1:0] code_q, code_d;
  logic [3:0]            btn_q, btn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2:0]            step_q, step_d;
  logic [2:0]            step_nx;
  logic [1:0]            sym_nx;
  logic                  load;
  logic [TW-1:0]         load_val;
  logic                  expire;

  assign step_nx = step_q + 3'd1;
  assign sym_nx  = 2'(code_q >> {step_nx, 1'b0});

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  // Next-state and registered-output values; btn holds its value within a phase.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    btn_d    = btn_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    step_d   = step_q;
    load     = 1'b0;
    load_val = HOLD_LD;
    case (state_q)
      IDLE: begin
        btn_d  = '0;
        busy_d = 1'b0;
        step_d = '0;
        if (bus.start) begin
          code_d  = bus.code;
          btn_d   = sym_to_onehot(bus.code[1:0]);
          busy_d  = 1'b1;
          state_d = PRESS;
          load    = 1'b1;
        end
      end
      PRESS: begin
        if (bus.abort) begin
          state_d = IDLE;
          btn_d   = '0;
          busy_d  = 1'b0;
          step_d  = '0;
        end else if (expire) begin
          state_d  = RELEASE;
          btn_d    = '0;
          load     = 1'b1;
          load_val = GAP_LD;
        end
      end
      RELEASE: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          step_d  = '0;
        end else if (expire) begin
          if (step_q < LAST_STEP) begin
            state_d = PRESS;
            step_d  = step_nx;
            btn_d   = sym_to_onehot(sym_nx);
            load    = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            step_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        btn_d   = '0;
        busy_d  = 1'b0;
        step_d  = '0;
      end
    endcase
  end

  // State and output registers; reset overrides start and abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      btn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
    end
  end

  assign bus.btn  = btn_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// tb/tb_lock_code_sender.sv - scoreboard bench for the lock code sender
module tb_lock_code_sender;

  localparam int L = 4;
  localparam int H = 3;
  localparam int G = 2;
  localparam int P = H + G;

  typedef struct {
    logic [3:0] btn;
    logic       busy;
    logic       done;
    logic [2:0] step;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];

  lock_code_sender_if #(.CODE_LEN(L)) bus ();

  lock_code_sender #(
    .CODE_LEN    (L),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end else begin
      n_pass++;
    end
  endtask

  // Expected outputs rel cycles after the start edge, from the documented timeline.
  function automatic exp_t seq_exp(input logic [7:0] code, input int rel);
    exp_t e;
    int   k;
    int   ph;
    logic [1:0] sym;
    e.btn  = 4'b0000;
    e.busy = 1'b0;
    e.done = 1'b0;
    e.step = 3'd0;
    if (rel >= 1 && rel <= L * P) begin
      k      = (rel - 1) / P;
      ph     = (rel - 1) % P;
      sym    = code[2*k +: 2];
      e.busy = 1'b1;
      e.step = 3'(k);
      if (ph < H) e.btn = 4'b0001 << sym;
    end else if (rel == L * P + 1) begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input int sc, input int c);
    exp_t e;
    int   rel;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.code  = 8'hE4;
    rst       = 1'b0;
    case (sc)
      1: begin
        bus.start = (c == 0);
        e = seq_exp(8'hE4, c);
      end
      2: begin
        bus.start = (c == 0 || c == 7);
        bus.code  = (c >= 7) ? 8'h00 : 8'hE4;
        e = seq_exp(8'hE4, c);
      end
      3: begin
        bus.start = (c == 0 || c == 15);
        bus.abort = (c == 12);
        e = (c <= 12) ? seq_exp(8'hE4, c) : seq_exp(8'hE4, c - 15);
      end
      4: begin
        bus.start = 1'b1;
        rel = (c <= 21) ? c : ((c <= 42) ? c - 21 : c - 42);
        e = seq_exp(8'hE4, rel);
      end
      5: begin
        bus.start = (c == 0 || c == 2 || c == 3);
        rst       = (c == 2 || c == 3);
        e = (c <= 2) ? seq_exp(8'hE4, c) : seq_exp(8'hE4, -1);
      end
      default: begin
        bus.code  = 8'h1B;
        bus.start = (c == 0);
        bus.abort = (c == 0 || c == 24);
        e = seq_exp(8'h1B, c);
      end
    endcase
    exp_q.push_back(e);
  endtask

  task automatic run_scn(input int sc, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      drive(sc, c);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check($sformatf("s%0d_c%0d_queue", sc, c), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("s%0d_c%0d_btn", sc, c),  32'(bus.btn),  32'(e.btn));
        check($sformatf("s%0d_c%0d_busy", sc, c), 32'(bus.busy), 32'(e.busy));
        check($sformatf("s%0d_c%0d_done", sc, c), 32'(bus.done), 32'(e.done));
        check($sformatf("s%0d_c%0d_step", sc, c), 32'(bus.step), 32'(e.step));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.code  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.code  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_btn",  32'(bus.btn),  32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_step", 32'(bus.step), 32'd0);
    @(posedge clk);
    #1;

    do_reset(); run_scn(1, 23);
    do_reset(); run_scn(2, 23);
    do_reset(); run_scn(3, 22);
    do_reset(); run_scn(4, 44);
    do_reset(); run_scn(5, 6);
    do_reset(); run_scn(6, 26);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
